// File: rtl/psum_acc_ctrl_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : psum_acc_ctrl_if
//  Brief    : Job configuration, PE-data handshake, adder-tree operand/result
//             and final-result handshake bundle for psum_acc_ctrl.
//  Revision : 1.0  initial release
// ============================================================================
interface psum_acc_ctrl_if #(
  parameter int DWIDTH = 25,
  parameter int CNT_W  = 8
) ();

  // job configuration / status
  logic                     cfg_start;
  logic [CNT_W-1:0]         cfg_ch_num;
  logic                     busy;

  // PE-data handshake (one beat = one channel pass)
  logic                     in_valid;
  logic                     in_ready;

  // adder-tree operand / result
  logic                     add_en;
  logic signed [DWIDTH-1:0] psum_in;
  logic signed [DWIDTH-1:0] psum_out;

  // final-result handshake
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DWIDTH-1:0] out_data;

  // controller side
  modport slave (
    input  cfg_start, cfg_ch_num, in_valid, psum_out, out_ready,
    output busy, in_ready, add_en, psum_in, out_valid, out_data
  );

  // environment side (sequencer, PE array, adder tree, result sink)
  modport master (
    output cfg_start, cfg_ch_num, in_valid, psum_out, out_ready,
    input  busy, in_ready, add_en, psum_in, out_valid, out_data
  );

endinterface
`default_nettype wire

// File: rtl/psum_acc_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : psum_acc_ctrl
//  Brief    : Partial-sum accumulation controller. Runs cfg_ch_num channel
//             passes through an external 2-cycle adder tree, feeding the
//             running sum back as psum_in, then presents the final sum.
//  Options  : PSUM_BIAS_EN - adds bias_in; accumulator starts from bias_in
//             instead of zero.
//  Revision : 1.0  initial release
// ============================================================================
module psum_acc_ctrl #(
  parameter int DWIDTH = 25,
  parameter int CNT_W  = 8
) (
  input  wire logic                     clk,
  input  wire logic                     rstn,
`ifdef PSUM_BIAS_EN
  input  wire logic signed [DWIDTH-1:0] bias_in,
`endif
  psum_acc_ctrl_if.slave                bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT1 = 3'd2;
  localparam logic [2:0] S_WAIT2 = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]               r_state;
  logic [2:0]               w_next;
  logic signed [DWIDTH-1:0] r_acc;
  logic [CNT_W-1:0]         r_cnt;
  logic [CNT_W-1:0]         r_ch_total;
  logic signed [DWIDTH-1:0] w_init;
  logic [CNT_W:0]           w_cnt_inc;
  logic                     w_last;
  logic                     w_load;

  // Starting value of the accumulator for a new job.
`ifdef PSUM_BIAS_EN
  assign w_init = bias_in;
`else
  assign w_init = '0;
`endif

  // One extra bit so a full-scale channel count never wraps in the compare.
  assign w_cnt_inc = {1'b0, r_cnt} + {{CNT_W{1'b0}}, 1'b1};
  assign w_last    = (w_cnt_inc == {1'b0, r_ch_total});
  assign w_load    = (r_state == S_IDLE) && bus.cfg_start;

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state: one pass is ISSUE -> WAIT1 -> WAIT2 to cover adder latency.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (bus.cfg_start) w_next = S_ISSUE;
      S_ISSUE: if (bus.in_valid)  w_next = S_WAIT1;
      S_WAIT1: w_next = S_WAIT2;
      S_WAIT2: w_next = w_last ? S_DONE : S_ISSUE;
      S_DONE:  if (bus.out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs decoded from the current state; data outputs mirror the register.
  always_comb begin
    bus.busy      = (r_state != S_IDLE);
    bus.in_ready  = (r_state == S_ISSUE);
    bus.add_en    = (r_state == S_ISSUE) && bus.in_valid;
    bus.out_valid = (r_state == S_DONE);
    bus.psum_in   = r_acc;
    bus.out_data  = r_acc;
  end

  // Job setup on start, accumulator capture and pass count in WAIT2.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_acc      <= '0;
      r_cnt      <= '0;
      r_ch_total <= {{(CNT_W-1){1'b0}}, 1'b1};
    end else if (w_load) begin
      r_acc      <= w_init;
      r_cnt      <= '0;
      r_ch_total <= (bus.cfg_ch_num == '0) ? {{(CNT_W-1){1'b0}}, 1'b1}
                                           : bus.cfg_ch_num;
    end else if (r_state == S_WAIT2) begin
      r_acc      <= bus.psum_out;
      r_cnt      <= w_cnt_inc[CNT_W-1:0];
    end
  end

endmodule
`default_nettype wire
